soc_system_pio_ext: RTL and testbench

Parametrised Avalon-MM output PIO, successor to the fixed 18-bit output PIO in soc_system.
- Width and reset value are configurable.
- Atomic set/clear/toggle write registers remove read-modify-write races between HPS threads.
- A hardware one-shot pulse engine drives selected bits high for a programmed number of clk cycles, then clears them.
- Sits on the lightweight HPS-to-FPGA bridge; out_port drives fabric logic (LEDs, strobes, control lines).

---
 rtl/soc_system_pio_ext_if.sv | 22 ++
 rtl/soc_system_pio_ext.sv | 160 ++++++++++++++++
 tb/tb_soc_system_pio_ext.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_pio_ext_if.sv
// Avalon-MM slave bus bundle for soc_system_pio_ext.
// Handshake: zero-wait-state Avalon-MM. A write is accepted on every clk
// edge where chipselect is high and write_n is low. There is no
// waitrequest. readdata is combinational from address and valid in the
// same cycle, regardless of chipselect.
interface soc_system_pio_ext_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_ext.sv
// Parametrised Avalon-MM output PIO with atomic set/clear/toggle registers
// and a one-shot pulse engine. The pulse engine drives selected bits high
// for PULSE_LEN cycles, then clears them.
// Optional macro PIO_EXT_IRQ_EN adds IRQ_STATUS/IRQ_MASK registers and the
// pulse-done interrupt. Without the macro, irq is tied 0 and addresses 6/7
// read 0.
module soc_system_pio_ext #(
    parameter int unsigned              DATA_WIDTH      = 18,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE     = '0,
    parameter int unsigned              PULSE_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    soc_system_pio_ext_if.slave    bus,
    output logic [DATA_WIDTH-1:0]  out_port,
    output logic                   irq,
    output logic                   dbg_state
);
    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned PCW = PULSE_CNT_WIDTH;
    localparam logic [PCW-1:0] CNT_ONE = PCW'(1);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   mask_q, mask_d;
    logic [PCW-1:0]  len_q, len_d;
    logic [PCW-1:0]  cnt_q, cnt_d;

    logic            wr;
    logic [DW-1:0]   wd;
    logic            start;
    logic            done;
    logic            unused_bits;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wd    = bus.writedata[DW-1:0];
    // A start with an empty mask or a zero length is a no-op.
    assign start = wr && (bus.address == 3'd5) && (wd != '0) && (len_q != '0);

    assign unused_bits = ^{bus.writedata, done};

    // Pulse FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Pulse FSM next state: (re)start wins over expiry; count 0 in ACTIVE is forced back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (start)                state_d = S_ACTIVE;
                else if (cnt_q <= CNT_ONE) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs and register updates: CPU write first, then pulse start or expiry clear.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        done   = 1'b0;
        if (wr) begin
            case (bus.address)
                3'd0:    data_d = wd;
                3'd1:    data_d = data_q | wd;
                3'd2:    data_d = data_q & ~wd;
                3'd3:    data_d = data_q ^ wd;
                3'd4:    len_d  = bus.writedata[PCW-1:0];
                default: ;
            endcase
        end
        if (start) begin
            // Retrigger simply replaces the mask; previously owned bits stay high.
            data_d = data_d | wd;
            mask_d = wd;
            cnt_d  = len_q;
        end else if (state_q == S_ACTIVE) begin
            if (cnt_q == CNT_ONE) begin
                data_d = data_d & ~mask_q;
                mask_d = '0;
                cnt_d  = '0;
                done   = 1'b1;
            end else if (cnt_q == '0) begin
                mask_d = '0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef PIO_EXT_IRQ_EN
    logic irq_status_q, irq_status_d;
    logic irq_mask_q, irq_mask_d;

    // Interrupt status (W1C, set wins) and mask.
    always_comb begin
        irq_status_d = irq_status_q;
        irq_mask_d   = irq_mask_q;
        if (wr && bus.address == 3'd6 && bus.writedata[0]) irq_status_d = 1'b0;
        if (wr && bus.address == 3'd7)                    irq_mask_d   = bus.writedata[0];
        if (done)                                         irq_status_d = 1'b1;
    end

    // Interrupt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_status_q <= 1'b0;
            irq_mask_q   <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
        end
    end

    assign irq = irq_status_q & irq_mask_q;
`else
    assign irq = 1'b0;
`endif

    // Zero-wait-state read mux; unused bits read 0.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata = 32'(data_q);
            3'd4:    bus.readdata = 32'(len_q);
            3'd5:    bus.readdata = 32'({mask_q, (state_q == S_ACTIVE)});
`ifdef PIO_EXT_IRQ_EN
            3'd6:    bus.readdata = {31'd0, irq_status_q};
            3'd7:    bus.readdata = {31'd0, irq_mask_q};
`endif
            default: bus.readdata = '0;
        endcase
    end

    assign out_port  = data_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_soc_system_pio_ext.sv
// Self-checking bench for soc_system_pio_ext with a cycle-level
// "remaining pulse cycles" reference model.
module tb_soc_system_pio_ext;
    localparam int DW  = 18;
    localparam int PCW = 16;
    localparam logic [DW-1:0] RV = 18'h000A5;
`ifdef PIO_EXT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] out_port;
    logic          irq;
    logic          dbg_state;

    soc_system_pio_ext_if bus ();

    soc_system_pio_ext #(
        .DATA_WIDTH(DW), .RESET_VALUE(RV), .PULSE_CNT_WIDTH(PCW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .out_port(out_port), .irq(irq), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0]  m_data;
    logic [DW-1:0]  m_mask;
    logic [PCW-1:0] m_len;
    int             m_remain;   // cycles the pulse bits still stay high
    bit             m_irq_st;
    bit             m_irq_mask;

    task automatic model_reset();
        m_data = RV; m_mask = '0; m_len = '0; m_remain = 0;
        m_irq_st = 1'b0; m_irq_mask = 1'b0;
    endtask

    task automatic model_step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
        logic [DW-1:0] v;
        bit wr, started, fin;
        v = d[DW-1:0]; wr = cs && !wn; started = 0; fin = 0;
        if (wr) begin
            case (a)
                3'd0: m_data = v;
                3'd1: m_data = m_data | v;
                3'd2: m_data = m_data & ~v;
                3'd3: m_data = m_data ^ v;
                3'd4: m_len = d[PCW-1:0];
                3'd5: if (v != 0 && m_len != 0) begin
                    m_data = m_data | v; m_mask = v; m_remain = int'(m_len); started = 1;
                end
                3'd6: if (IRQ_EN && d[0]) m_irq_st = 1'b0;
                3'd7: if (IRQ_EN) m_irq_mask = d[0];
                default: ;
            endcase
        end
        if (!started && m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
                m_data = m_data & ~m_mask; m_mask = '0; fin = 1;
            end
        end
        if (fin && IRQ_EN) m_irq_st = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r = 32'(m_data);
            3'd4: r = 32'(m_len);
            3'd5: r = 32'({m_mask, (m_remain != 0)});
            3'd6: r = IRQ_EN ? {31'd0, m_irq_st} : 32'd0;
            3'd7: r = IRQ_EN ? {31'd0, m_irq_mask} : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit model_irq();
        return IRQ_EN && m_irq_st && m_irq_mask;
    endfunction

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic reset_dut();
        reset = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        @(posedge clk); model_reset();
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic cyc(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = cs; bus.write_n = wn; bus.address = a; bus.writedata = d;
        @(posedge clk); model_step(cs, wn, a, d);
        @(negedge clk); bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic rd(input logic [2:0] a);
        bus.address = a; #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        n_checks++; if (out_port !== RV) begin n_errors++; $display("FAIL reset_out_port: got %h exp %h", out_port, RV); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        n_checks++; if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL reset_state: got %b exp 0", dbg_state); end
        rd(3'd0);
        n_checks++; if (bus.readdata !== 32'(RV)) begin n_errors++; $display("FAIL reset_rd_data: got %h exp %h", bus.readdata, 32'(RV)); end
        for (int a = 4; a < 8; a++) begin
            rd(3'(a));
            n_checks++; if (bus.readdata !== 32'd0) begin n_errors++; $display("FAIL reset_rd_addr%0d: got %h exp 0", a, bus.readdata); end
        end
    endtask

    task automatic test_data();
        wr(3'd0, 32'h0002AAAA);
        n_checks++; if (out_port !== 18'h2AAAA) begin n_errors++; $display("FAIL data_write: got %h exp 2aaaa", out_port); end
        rd(3'd0);
        n_checks++; if (bus.readdata !== 32'h0002AAAA) begin n_errors++; $display("FAIL data_read: got %h exp 0002aaaa", bus.readdata); end
        wr(3'd0, 32'hFFFC0001);
        n_checks++; if (out_port !== 18'h00001) begin n_errors++; $display("FAIL data_upper_ignored: got %h exp 00001", out_port); end
        cyc(1'b0, 1'b0, 3'd0, 32'h3FFFF);
        n_checks++; if (out_port !== 18'h00001) begin n_errors++; $display("FAIL data_no_cs: got %h exp 00001", out_port); end
        reset_dut();
        n_checks++; if (out_port !== RV) begin n_errors++; $display("FAIL data_rereset: got %h exp %h", out_port, RV); end
    endtask

    task automatic test_atomic();
        wr(3'd0, 32'h000F0);
        wr(3'd1, 32'h3);
        n_checks++; if (out_port !== 18'h000F3) begin n_errors++; $display("FAIL outset: got %h exp 000f3", out_port); end
        wr(3'd2, 32'h10);
        n_checks++; if (out_port !== 18'h000E3) begin n_errors++; $display("FAIL outclr: got %h exp 000e3", out_port); end
        wr(3'd3, 32'h101);
        n_checks++; if (out_port !== 18'h001E2) begin n_errors++; $display("FAIL toggle: got %h exp 001e2", out_port); end
        for (int a = 1; a < 4; a++) begin
            rd(3'(a));
            n_checks++; if (bus.readdata !== 32'd0) begin n_errors++; $display("FAIL rd_wo_addr%0d: got %h exp 0", a, bus.readdata); end
        end
        for (int i = 0; i < 40; i++) begin
            wr(3'($urandom_range(0, 3)), $urandom);
            n_checks++; if (out_port !== m_data) begin n_errors++; $display("FAIL atomic_rand%0d: got %h exp %h", i, out_port, m_data); end
        end
    endtask

    task automatic test_pulse();
        int high;
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd5);
        wr(3'd5, 32'h4);
        rd(3'd5);
        n_checks++; if (bus.readdata !== 32'h9) begin n_errors++; $display("FAIL pulse_status_active: got %h exp 9", bus.readdata); end
        high = out_port[2] ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (out_port[2]) high++;
            n_checks++; if (out_port !== m_data || dbg_state !== (m_remain != 0)) begin
                n_errors++; $display("FAIL pulse_cycle%0d: got %h/%b exp %h/%b", i, out_port, dbg_state, m_data, (m_remain != 0));
            end
        end
        n_checks++; if (high != 5) begin n_errors++; $display("FAIL pulse_width: got %0d exp 5", high); end
        rd(3'd5);
        n_checks++; if (bus.readdata !== 32'h0) begin n_errors++; $display("FAIL pulse_status_after: got %h exp 0", bus.readdata); end
    endtask

    task automatic test_retrigger();
        int high;
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd10);
        wr(3'd5, 32'h1);
        idle(); idle(); idle();
        wr(3'd5, 32'h2);
        high = out_port[1] ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (out_port[1]) high++;
        end
        n_checks++; if (high != 10) begin n_errors++; $display("FAIL retrig_width: got %0d exp 10", high); end
        n_checks++; if (out_port !== 18'h1) begin n_errors++; $display("FAIL retrig_old_bit: got %h exp 00001", out_port); end
        wr(3'd5, 32'h0);
        n_checks++; if (dbg_state !== 1'b0 || out_port !== 18'h1) begin n_errors++; $display("FAIL start_zero_mask: got %b/%h exp 0/00001", dbg_state, out_port); end
        wr(3'd5, 32'hFFFC0000);
        n_checks++; if (dbg_state !== 1'b0 || out_port !== 18'h1) begin n_errors++; $display("FAIL start_upper_mask: got %b/%h exp 0/00001", dbg_state, out_port); end
        wr(3'd4, 32'd0);
        wr(3'd5, 32'h4);
        n_checks++; if (dbg_state !== 1'b0 || out_port !== 18'h1) begin n_errors++; $display("FAIL start_len0: got %b/%h exp 0/00001", dbg_state, out_port); end
    endtask

    task automatic test_collision();
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd2);
        wr(3'd5, 32'h3);
        idle();
        wr(3'd0, 32'h3FFFF);
        n_checks++; if (out_port !== 18'h3FFFC) begin n_errors++; $display("FAIL expiry_vs_write: got %h exp 3fffc", out_port); end
        n_checks++; if (out_port !== m_data) begin n_errors++; $display("FAIL expiry_model: got %h exp %h", out_port, m_data); end
    endtask

    task automatic test_reset_mid_pulse();
        wr(3'd7, 32'd1);
        wr(3'd4, 32'd5);
        wr(3'd5, 32'h10);
        idle(); idle();
        reset_dut();
        rd(3'd5);
        n_checks++; if (out_port !== RV) begin n_errors++; $display("FAIL midreset_out: got %h exp %h", out_port, RV); end
        n_checks++; if (bus.readdata !== 32'd0) begin n_errors++; $display("FAIL midreset_status: got %h exp 0", bus.readdata); end
        for (int i = 0; i < 5; i++) begin
            idle();
            n_checks++; if (irq !== 1'b0 || out_port !== RV) begin n_errors++; $display("FAIL midreset_quiet%0d: got %b/%h exp 0/%h", i, irq, out_port, RV); end
        end
    endtask

    task automatic test_irq();
        bit fell;
        wr(3'd0, 32'h8);
        wr(3'd7, 32'd1);
        wr(3'd4, 32'd3);
        wr(3'd5, 32'h8);
        fell = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (!fell && !out_port[3]) begin
                fell = 1;
                n_checks++; if (irq !== IRQ_EN) begin n_errors++; $display("FAIL irq_on_expiry: got %b exp %b", irq, IRQ_EN); end
            end
            n_checks++; if (irq !== model_irq()) begin n_errors++; $display("FAIL irq_cycle%0d: got %b exp %b", i, irq, model_irq()); end
        end
        n_checks++; if (!fell) begin n_errors++; $display("FAIL irq_pulse_end: got no expiry exp expiry"); end
        rd(3'd6);
        n_checks++; if (bus.readdata !== model_read(3'd6)) begin n_errors++; $display("FAIL irq_status_rd: got %h exp %h", bus.readdata, model_read(3'd6)); end
        wr(3'd6, 32'd1);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_w1c: got %b exp 0", irq); end
        wr(3'd4, 32'd2);
        wr(3'd5, 32'h8);
        idle();
        wr(3'd6, 32'd1);
        n_checks++; if (irq !== IRQ_EN) begin n_errors++; $display("FAIL irq_set_wins: got %b exp %b", irq, IRQ_EN); end
        rd(3'd7);
        n_checks++; if (bus.readdata !== model_read(3'd7)) begin n_errors++; $display("FAIL irq_mask_rd: got %h exp %h", bus.readdata, model_read(3'd7)); end
    endtask

    task automatic test_random();
        logic [2:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd4) d = 32'($urandom_range(0, 6));
            if (a == 3'd5) d = d & 32'h0001_0F0F;
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), a, d);
            n_checks++; if (out_port !== m_data || irq !== model_irq() || dbg_state !== (m_remain != 0)) begin
                n_errors++; $display("FAIL rand%0d: got %h/%b/%b exp %h/%b/%b", i, out_port, irq, dbg_state, m_data, model_irq(), (m_remain != 0));
            end
            a = 3'($urandom_range(0, 7));
            rd(a);
            n_checks++; if (bus.readdata !== model_read(a)) begin n_errors++; $display("FAIL rand_rd%0d addr%0d: got %h exp %h", i, a, bus.readdata, model_read(a)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_data();
        test_atomic();
        test_pulse();
        test_retrigger();
        test_collision();
        test_reset_mid_pulse();
        test_irq();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
